alu_74181_seq: RTL and testbench

Nibble-serial sequencer that runs a wide arithmetic operation through a single 4-bit 74181-style arithmetic slice (`alu_74181_arith`, instantiated internally). It latches a wide operand pair and a 4-bit function select, then feeds the slice one nibble per clock, LSB nibble first. The carry-out of each nibble is chained into the carry-in of the next. It sits between the register/IO front end and the slice, and exposes a valid/ready request channel and a valid/ready result channel.

---
 rtl/alu_74181_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_74181_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_74181_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_74181_seq (with internal slice alu_74181_arith)
// Purpose  : Nibble-serial wide arithmetic through one 4-bit 74181-style slice.
//            Optional macro ALU_SEQ_ZERO_FLAG_EN adds the res_zero output.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 4-bit arithmetic slice (M=0 functions, active-high data, active-high carry).
// ----------------------------------------------------------------------------
module alu_74181_arith (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_s,
    input  logic       i_cn,
    output logic [3:0] o_f,
    output logic       o_cn4
);

    logic [3:0] w_x;
    logic [3:0] w_y;
    logic [4:0] w_sum;

    // Every function is expressed as x + y + cn so the carry-out is the 5th sum bit.
    always_comb begin
        w_x = 4'h0;
        w_y = 4'h0;
        case (i_s)
            4'b0000: begin w_x = i_a;                w_y = 4'h0;               end
            4'b0001: begin w_x = i_a | i_b;          w_y = 4'h0;               end
            4'b0010: begin w_x = i_a | ~i_b;         w_y = 4'h0;               end
            4'b0011: begin w_x = 4'h0;               w_y = 4'hF;               end
            4'b0100: begin w_x = i_a;                w_y = i_a & ~i_b;         end
            4'b0101: begin w_x = i_a | i_b;          w_y = i_a & ~i_b;         end
            4'b0110: begin w_x = i_a;                w_y = ~i_b;               end
            4'b0111: begin w_x = i_a & ~i_b;         w_y = 4'hF;               end
            4'b1000: begin w_x = i_a;                w_y = i_a & i_b;          end
            4'b1001: begin w_x = i_a;                w_y = i_b;                end
            4'b1010: begin w_x = i_a | ~i_b;         w_y = i_a & i_b;          end
            4'b1011: begin w_x = i_a & i_b;          w_y = 4'hF;               end
            4'b1100: begin w_x = i_a;                w_y = i_a;                end
            4'b1101: begin w_x = i_a | i_b;          w_y = i_a;                end
            4'b1110: begin w_x = i_a | ~i_b;         w_y = i_a;                end
            default: begin w_x = i_a;                w_y = 4'hF;               end
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, i_cn};
    assign o_f   = w_sum[3:0];
    assign o_cn4 = w_sum[4];

endmodule

// ----------------------------------------------------------------------------
// Sequencer top
// ----------------------------------------------------------------------------
module alu_74181_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [3:0]           op_s,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] res_f,
    output logic                 res_cout,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic                 res_zero,
`endif
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);

    localparam logic [CW-1:0] C_LAST = CW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic [3:0]    r_op;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    // Upper W-4 bits of the result shifter; the newest nibble enters at the top.
    logic [W-5:0]  r_r;
    logic [W-1:0]  r_res_f;
    logic          r_res_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic          r_res_zero;
`endif

    logic [3:0]    w_f;
    logic          w_cn4;
    logic [W-1:0]  w_r_next;
    logic          w_accept;
    logic          w_last;

    alu_74181_arith u_slice (
        .i_a   (r_a_sh[3:0]),
        .i_b   (r_b_sh[3:0]),
        .i_s   (r_op),
        .i_cn  (r_carry),
        .o_f   (w_f),
        .o_cn4 (w_cn4)
    );

    assign w_r_next = {w_f, r_r};
    assign w_accept = (r_state == S_IDLE) && start_valid;
    assign w_last   = (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_op       <= 4'h0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_r        <= '0;
            r_res_f    <= '0;
            r_res_cout <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            r_res_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh  <= a_in;
                        r_b_sh  <= b_in;
                        r_op    <= op_s;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_r     <= w_r_next[W-1:4];
                    r_a_sh  <= {4'h0, r_a_sh[W-1:4]};
                    r_b_sh  <= {4'h0, r_b_sh[W-1:4]};
                    r_carry <= w_cn4;
                    if (w_last) begin
                        // Result outputs are frozen here until the next operation completes.
                        r_res_f    <= w_r_next;
                        r_res_cout <= w_cn4;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        r_res_zero <= (w_r_next == '0);
`endif
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign res_valid   = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign res_f       = r_res_f;
    assign res_cout    = r_res_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign res_zero    = r_res_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_74181_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_74181_seq
// Purpose  : Directed plus randomised self-checking bench for alu_74181_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_74181_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [3:0]   op_s;
    logic         cin;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_f;
    logic         res_cout;
    logic         busy;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic         res_zero;
`endif

    int checks;
    int failures;

    alu_74181_seq #(.NIBBLES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_s        (op_s),
        .cin         (cin),
        .a_in        (a_in),
        .b_in        (b_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_f       (res_f),
        .res_cout    (res_cout),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .res_zero    (res_zero),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference 4-bit slice written from the 74181 arithmetic function table.
    function automatic logic [4:0] ref_slice(input logic [3:0] s, input logic [3:0] a,
                                             input logic [3:0] b, input logic cn);
        int av, bv, nb, c, t;
        av = int'(a); bv = int'(b); nb = 15 - bv; c = int'(cn);
        case (s)
            4'h0: t = av + c;
            4'h1: t = (av | bv) + c;
            4'h2: t = (av | nb) + c;
            4'h3: t = 15 + c;
            4'h4: t = av + (av & nb) + c;
            4'h5: t = (av | bv) + (av & nb) + c;
            4'h6: t = av + nb + c;
            4'h7: t = (av & nb) + 15 + c;
            4'h8: t = av + (av & bv) + c;
            4'h9: t = av + bv + c;
            4'hA: t = (av | nb) + (av & bv) + c;
            4'hB: t = (av & bv) + 15 + c;
            4'hC: t = av + av + c;
            4'hD: t = (av | bv) + av + c;
            4'hE: t = (av | nb) + av + c;
            default: t = av + 15 + c;
        endcase
        return 5'(t);
    endfunction

    function automatic logic [W:0] ref_wide(input logic [3:0] s, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic c0);
        logic [W-1:0] f;
        logic         c;
        logic [4:0]   r;
        f = '0;
        c = c0;
        for (int k = 0; k < N; k++) begin
            r = ref_slice(s, a[4*k +: 4], b[4*k +: 4], c);
            f[4*k +: 4] = r[3:0];
            c = r[4];
        end
        return {c, f};
    endfunction

    // Issues one request from a point #1 after a rising edge and drains the result.
    task automatic run_req(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input int hold,
                           input logic [W-1:0] exp_f, input logic exp_c);
        int lat;
        start_valid = 1'b1;
        op_s = op; a_in = a; b_in = b; cin = c;
        chk("start_ready_idle", 64'(start_ready), 64'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        op_s = 4'($urandom); a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(N));
        chk("res_f", 64'(res_f), 64'(exp_f));
        chk("res_cout", 64'(res_cout), 64'(exp_c));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("res_zero", 64'(res_zero), 64'(exp_f == '0));
`endif
        for (int i = 0; i < hold; i++) begin
            start_valid = (i == 3);
            @(posedge clk); #1;
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_f", 64'(res_f), 64'(exp_f));
            chk("bp_start_ready", 64'(start_ready), 64'd0);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("drain_valid", 64'(res_valid), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
        chk("hold_f_idle", 64'(res_f), 64'(exp_f));
    endtask

    initial begin
        logic [3:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        logic         r_c;
        logic [W:0]   r_exp;

        checks = 0; failures = 0;
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        op_s = 4'h0; cin = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", 64'(start_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_f", 64'(res_f), 64'd0);
        chk("rst_res_cout", 64'(res_cout), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed: addition, carry ripple, doubling with carry-in.
        run_req(4'b1001, 16'h1234, 16'h0FCD, 1'b0, 0, 16'h2201, 1'b0);
        run_req(4'b1001, 16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1);
        run_req(4'b1100, 16'h8001, 16'h5A5A, 1'b1, 0, 16'h0003, 1'b1);

        // Reset in the middle of a run discards the operation.
        start_valid = 1'b1; op_s = 4'b1001; a_in = 16'h1111; b_in = 16'h2222; cin = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_start_ready", 64'(start_ready), 64'd1);
        chk("midrun_res_valid", 64'(res_valid), 64'd0);
        chk("midrun_busy", 64'(busy), 64'd0);
        chk("midrun_res_f", 64'(res_f), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-pressure for 10 cycles with an ignored start pulse; subtraction A-B-1+1.
        run_req(4'b0110, 16'h5000, 16'h0001, 1'b1, 10, 16'h4FFF, 1'b1);
        run_req(4'b1001, 16'h1234, 16'h0FCD, 1'b0, 0, 16'h2201, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            r_op = 4'($urandom); r_a = W'($urandom); r_b = W'($urandom); r_c = 1'($urandom);
            r_exp = ref_wide(r_op, r_a, r_b, r_c);
            run_req(r_op, r_a, r_b, r_c, int'($urandom_range(0, 3)), r_exp[W-1:0], r_exp[W]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
